pmcc_matrix_pulse_controller: RTL and testbench
===============================================

# pmcc_matrix_pulse_controller

Parametrised successor to the pixel-matrix control register of the PMC coprocessor. It drives NUM_SIGNALS matrix control lines (clk_sh, sh_a, sh_b, gate, strobe, store) independently per column, selected by a column mask. It adds a timed-pulse mode: the controller applies a level, holds it for a programmed number of cycles, then restores the previous state without further commands. It sits between the PMCC instruction decoder and the pixel-matrix control pins.

## Interface
Parameters:
- COLUMNS, 32, number of matrix columns driven
- NUM_SIGNALS, 6, number of control lines per column
- CNT_W, 8, width of the pulse-length field

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- soft_clr  in  1  synchronous clear (driven by the PMCC reset register)
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_mode  in  1  0 = static write, 1 = timed pulse
- cmd_level  in  NUM_SIGNALS  level applied per signal
- cmd_mask  in  COLUMNS  1 = column affected
- cmd_len  in  CNT_W  pulse length in cycles
- busy  out  1  pulse in progress
- ctrl_out  out  NUM_SIGNALS×COLUMNS  matrix control lines; index 0..5 = clk_sh, sh_a, sh_b, gate, strobe, store

## Operation
- Clock: one clock, clk. Reset: rst_n, asynchronous, active-low.
- Reset value (rst_n low): ctrl_out all 0, busy 0, cmd_ready 1, state IDLE, counter 0, snapshot 0.
- FSM states are IDLE and PULSE. cmd_ready = (state == IDLE) && !soft_clr.
- Accept = cmd_valid && cmd_ready.
- Static accept (mode 0):
  - for every s, c with cmd_mask[c] = 1: ctrl_out[s][c] <= cmd_level[s].
  - Unmasked columns keep their value. State stays IDLE.
- Pulse accept (mode 1):
  - snapshot <= ctrl_out; the masked columns take cmd_level as in static mode.
  - counter <= max(cmd_len, 1) − 1; state goes to PULSE.
- In PULSE:
  - if counter == 0: ctrl_out <= snapshot and state goes to IDLE.
  - otherwise counter decrements.
  - cmd_valid is ignored while in PULSE.
- cmd_len = 0 behaves as cmd_len = 1.
- cmd_mask = 0: the command is accepted with no output change. In pulse mode it still occupies the controller for the programmed length.
- soft_clr has priority over everything: outputs, counter and snapshot go to 0 and state goes to IDLE at the next edge; any command offered in that cycle is dropped.
- rst_n asserted mid-pulse: immediate return to the reset values; no restore.

## Timing
- Static: command accepted at edge k → ctrl_out valid after edge k (1-cycle latency, registered).
- Pulse of length L (L ≥ 1):
  - level visible from edge k through edge k+L−1.
  - restored value visible after edge k+L.
  - busy high after edges k..k+L−1.
  - cmd_ready low for exactly L cycles; next accept possible at edge k+L+1.
- Back-to-back static commands: one per cycle.
- All outputs are registered; there are no combinational paths from cmd_* to ctrl_out or busy. cmd_ready depends combinationally only on state and soft_clr.

## Structure
- Package pmcc_matrix_pkg holds:
  - signal index constants (SIG_CLK_SH=0 … SIG_STORE=5)
  - cmd_mode enum (MODE_STATIC, MODE_PULSE)
  - FSM state enum
  - default parameter constants
- Sub-module pmcc_pulse_timer (CNT_W-bit down-counter):
  - inputs load, len, clr
  - output expire (counter == 0 while armed)
  - the top level owns the FSM, snapshot and output registers.

## Test plan
1. Reset, then static command with mask 0x0000_000F, level 6'b100001 → columns 0–3 show store = 1 and clk_sh = 1; all other columns stay 0; ready remains 1.
2. Pulse with mask 0xFFFF_FFFF, level strobe = 1, len 5 → strobe high for exactly 5 cycles after accept, busy high for 5 cycles, previous state restored on the 6th edge, cmd_valid held high during the pulse is not accepted until ready returns.
3. Pulse with len 0 → identical to len 1: one-cycle pulse, busy high for 1 cycle.
4. Overlap check: static write of gate = 1 on columns 0–15, then a pulse of gate = 0 on columns 8–23 for len 3 → after restore, columns 0–15 have gate = 1 and columns 16–23 have gate = 0.
5. soft_clr asserted in cycle 2 of a len-10 pulse, with cmd_valid high in the same cycle → all outputs 0 and busy 0 at the next edge, the command is not accepted, and ready is 1 the following cycle.
6. rst_n pulsed low asynchronously mid-pulse (not clock-aligned) → outputs 0 immediately; after deassertion, ready is 1 and a new static command works.

Source files
------------

// File: rtl/pmcc_matrix_pkg.sv
// Shared constants and types for the PMCC pixel-matrix pulse controller.
// Signal indices select the row of the flattened ctrl_out_o vector (row * COLUMNS + column).
package pmcc_matrix_pkg;

  localparam int unsigned SIG_CLK_SH = 0;
  localparam int unsigned SIG_SH_A   = 1;
  localparam int unsigned SIG_SH_B   = 2;
  localparam int unsigned SIG_GATE   = 3;
  localparam int unsigned SIG_STROBE = 4;
  localparam int unsigned SIG_STORE  = 5;

  localparam int unsigned DEFAULT_COLUMNS     = 32;
  localparam int unsigned DEFAULT_NUM_SIGNALS = 6;
  localparam int unsigned DEFAULT_CNT_W       = 8;

  typedef enum logic {
    MODE_STATIC = 1'b0,
    MODE_PULSE  = 1'b1
  } cmd_mode_e;

  typedef enum logic {
    StIdle  = 1'b0,
    StPulse = 1'b1
  } state_e;

endpackage

// File: rtl/pmcc_pulse_timer.sv
// Down-counter that times a pulse: load arms it with max(len,1)-1, expire flags the last cycle.
module pmcc_pulse_timer
  import pmcc_matrix_pkg::*;
#(
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] len_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;

  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (clr_i) begin
      cnt_d   = '0;
      armed_d = 1'b0;
    end else if (load_i) begin
      // A zero length is treated as a single-cycle pulse.
      cnt_d   = (len_i == '0) ? '0 : len_i - CNT_W'(1);
      armed_d = 1'b1;
    end else if (armed_q) begin
      if (cnt_q == '0) begin
        armed_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  assign expire_o = armed_q && (cnt_q == '0);

endmodule

// File: rtl/pmcc_matrix_pulse_controller.sv
// Per-column matrix control register with static writes and self-restoring timed pulses.
// ctrl_out_o is flattened as [signal * COLUMNS + column].
module pmcc_matrix_pulse_controller
  import pmcc_matrix_pkg::*;
#(
  parameter int unsigned COLUMNS     = DEFAULT_COLUMNS,
  parameter int unsigned NUM_SIGNALS = DEFAULT_NUM_SIGNALS,
  parameter int unsigned CNT_W       = DEFAULT_CNT_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           soft_clr_i,
  input  logic                           cmd_valid_i,
  output logic                           cmd_ready_o,
  input  logic                           cmd_mode_i,
  input  logic [NUM_SIGNALS-1:0]         cmd_level_i,
  input  logic [COLUMNS-1:0]             cmd_mask_i,
  input  logic [CNT_W-1:0]               cmd_len_i,
  output logic                           busy_o,
  output logic [NUM_SIGNALS*COLUMNS-1:0] ctrl_out_o
);

  localparam int unsigned Width = NUM_SIGNALS * COLUMNS;

  state_e           state_q;
  logic [Width-1:0] ctrl_q;
  logic [Width-1:0] snap_q;
  logic [Width-1:0] ctrl_masked;
  logic             accept;
  logic             pulse_load;
  logic             expire;

  assign cmd_ready_o = (state_q == StIdle) && !soft_clr_i;
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign pulse_load  = accept && (cmd_mode_i == MODE_PULSE);

  // Current outputs with the command level applied to the masked columns.
  always_comb begin
    ctrl_masked = ctrl_q;
    for (int s = 0; s < NUM_SIGNALS; s++) begin
      for (int c = 0; c < COLUMNS; c++) begin
        if (cmd_mask_i[c]) begin
          ctrl_masked[s*COLUMNS+c] = cmd_level_i[s];
        end
      end
    end
  end

  pmcc_pulse_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (soft_clr_i),
    .load_i   (pulse_load),
    .len_i    (cmd_len_i),
    .expire_o (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ctrl_q  <= '0;
      snap_q  <= '0;
    end else if (soft_clr_i) begin
      state_q <= StIdle;
      ctrl_q  <= '0;
      snap_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid_i) begin
            ctrl_q <= ctrl_masked;
            if (cmd_mode_i == MODE_PULSE) begin
              snap_q  <= ctrl_q;
              state_q <= StPulse;
            end
          end
        end
        StPulse: begin
          if (expire) begin
            ctrl_q  <= snap_q;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o     = (state_q == StPulse);
  assign ctrl_out_o = ctrl_q;

endmodule

// File: tb/tb_pmcc_matrix_pulse_controller.sv
// Directed bench for pmcc_matrix_pulse_controller: static writes, timed pulses, clears and reset.
module tb_pmcc_matrix_pulse_controller;
  import pmcc_matrix_pkg::*;

  localparam int COLS = 32;
  localparam int NS   = 6;
  localparam int CW   = 8;
  localparam int W    = NS * COLS;

  logic          clk;
  logic          rst_n;
  logic          soft_clr;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_mode;
  logic [NS-1:0] cmd_level;
  logic [COLS-1:0] cmd_mask;
  logic [CW-1:0] cmd_len;
  logic          busy;
  logic [W-1:0]  ctrl;

  int checks;
  int failures;

  logic [W-1:0] exp_a;
  logic [W-1:0] exp_b;
  logic [W-1:0] exp_p;

  pmcc_matrix_pulse_controller #(
    .COLUMNS     (COLS),
    .NUM_SIGNALS (NS),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .soft_clr_i  (soft_clr),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_mode_i  (cmd_mode),
    .cmd_level_i (cmd_level),
    .cmd_mask_i  (cmd_mask),
    .cmd_len_i   (cmd_len),
    .busy_o      (busy),
    .ctrl_out_o  (ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic mode, input logic [NS-1:0] level, input logic [COLS-1:0] mask,
                       input logic [CW-1:0] len);
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_level = level;
    cmd_mask  = mask;
    cmd_len   = len;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    soft_clr = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode = 1'b0;
    cmd_level = '0;
    cmd_mask = '0;
    cmd_len = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (ctrl !== '0) begin
      failures++; $display("FAIL reset_ctrl got=%h want=0", ctrl);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%b want=0", busy);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready got=%b want=1", cmd_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_static();
    // clk_sh + store on columns 0..3
    drive(MODE_STATIC, 6'b100001, 32'h0000_000F, 8'd0);
    @(negedge clk);
    exp_a = '0;
    exp_a[SIG_CLK_SH*COLS +: COLS] = 32'h0000_000F;
    exp_a[SIG_STORE*COLS +: COLS]  = 32'h0000_000F;
    checks++;
    if (ctrl !== exp_a) begin
      failures++; $display("FAIL static_ctrl got=%h want=%h", ctrl, exp_a);
    end
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL static_ready_busy got=%b%b want=10", cmd_ready, busy);
    end
    // back-to-back: sh_a on columns 4..7
    drive(MODE_STATIC, 6'b000010, 32'h0000_00F0, 8'd0);
    @(negedge clk);
    exp_b = exp_a;
    exp_b[SIG_SH_A*COLS +: COLS] = 32'h0000_00F0;
    checks++;
    if (ctrl !== exp_b) begin
      failures++; $display("FAIL b2b_static got=%h want=%h", ctrl, exp_b);
    end
    // empty mask changes nothing
    drive(MODE_STATIC, 6'b111111, 32'h0000_0000, 8'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (ctrl !== exp_b) begin
      failures++; $display("FAIL mask0_static got=%h want=%h", ctrl, exp_b);
    end
  endtask

  task automatic test_pulse();
    drive(MODE_PULSE, 6'b010000, 32'hFFFF_FFFF, 8'd5);
    exp_p = '0;
    exp_p[SIG_STROBE*COLS +: COLS] = 32'hFFFF_FFFF;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      checks++;
      if (ctrl !== exp_p || busy !== 1'b1 || cmd_ready !== 1'b0) begin
        failures++;
        $display("FAIL pulse_hold cyc=%0d got=%h busy=%b rdy=%b want=%h busy=1 rdy=0",
                 j, ctrl, busy, cmd_ready, exp_p);
      end
    end
    // cmd_valid still held: restore happens first
    @(negedge clk);
    checks++;
    if (ctrl !== exp_b || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL pulse_restore got=%h busy=%b rdy=%b want=%h busy=0 rdy=1",
               ctrl, busy, cmd_ready, exp_b);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (ctrl !== exp_p || busy !== 1'b1) begin
      failures++; $display("FAIL held_accept got=%h busy=%b want=%h busy=1", ctrl, busy, exp_p);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (ctrl !== exp_b || busy !== 1'b0) begin
      failures++; $display("FAIL held_restore got=%h busy=%b want=%h busy=0", ctrl, busy, exp_b);
    end
  endtask

  task automatic test_len0();
    drive(MODE_PULSE, 6'b001000, 32'h0000_0001, 8'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    exp_a = exp_b;
    exp_a[SIG_GATE*COLS] = 1'b1;
    exp_a[SIG_CLK_SH*COLS] = 1'b0;
    exp_a[SIG_STORE*COLS] = 1'b0;
    checks++;
    if (ctrl !== exp_a || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL len0_pulse got=%h busy=%b rdy=%b want=%h busy=1 rdy=0",
               ctrl, busy, cmd_ready, exp_a);
    end
    @(negedge clk);
    checks++;
    if (ctrl !== exp_b || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL len0_restore got=%h busy=%b rdy=%b want=%h busy=0 rdy=1",
               ctrl, busy, cmd_ready, exp_b);
    end
  endtask

  task automatic test_soft_clr_idle();
    soft_clr = 1'b1;
    drive(MODE_STATIC, 6'b111111, 32'hFFFF_FFFF, 8'd0);
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++; $display("FAIL clr_idle_ready got=%b want=0", cmd_ready);
    end
    @(negedge clk);
    soft_clr = 1'b0;
    cmd_valid = 1'b0;
    checks++;
    if (ctrl !== '0) begin
      failures++; $display("FAIL clr_idle_ctrl got=%h want=0", ctrl);
    end
  endtask

  task automatic test_overlap();
    drive(MODE_STATIC, 6'b001000, 32'h0000_FFFF, 8'd0);
    @(negedge clk);
    exp_b = '0;
    exp_b[SIG_GATE*COLS +: COLS] = 32'h0000_FFFF;
    checks++;
    if (ctrl !== exp_b) begin
      failures++; $display("FAIL overlap_static got=%h want=%h", ctrl, exp_b);
    end
    drive(MODE_PULSE, 6'b000000, 32'h00FF_FF00, 8'd3);
    exp_p = '0;
    exp_p[SIG_GATE*COLS +: COLS] = 32'h0000_00FF;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if (ctrl !== exp_p || busy !== 1'b1) begin
        failures++;
        $display("FAIL overlap_pulse cyc=%0d got=%h busy=%b want=%h busy=1", j, ctrl, busy, exp_p);
      end
    end
    @(negedge clk);
    checks++;
    if (ctrl !== exp_b || busy !== 1'b0) begin
      failures++; $display("FAIL overlap_restore got=%h busy=%b want=%h busy=0", ctrl, busy, exp_b);
    end
  endtask

  task automatic test_soft_clr_pulse();
    drive(MODE_PULSE, 6'b010000, 32'hFFFF_FFFF, 8'd10);
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL clr_pulse_start busy=%b want=1", busy);
    end
    @(negedge clk);
    soft_clr = 1'b1;
    drive(MODE_STATIC, 6'b111111, 32'hFFFF_FFFF, 8'd0);
    @(negedge clk);
    checks++;
    if (ctrl !== '0 || busy !== 1'b0) begin
      failures++; $display("FAIL clr_pulse_out got=%h busy=%b want=0 busy=0", ctrl, busy);
    end
    soft_clr = 1'b0;
    cmd_valid = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL clr_pulse_ready got=%b want=1", cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (ctrl !== '0 || busy !== 1'b0) begin
      failures++; $display("FAIL clr_pulse_dropped got=%h busy=%b want=0 busy=0", ctrl, busy);
    end
  endtask

  task automatic test_async_reset();
    drive(MODE_PULSE, 6'b000100, 32'h0000_00FF, 8'd8);
    @(negedge clk);
    cmd_valid = 1'b0;
    exp_p = '0;
    exp_p[SIG_SH_B*COLS +: COLS] = 32'h0000_00FF;
    checks++;
    if (ctrl !== exp_p || busy !== 1'b1) begin
      failures++; $display("FAIL arst_pulse got=%h busy=%b want=%h busy=1", ctrl, busy, exp_p);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ctrl !== '0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL arst_immediate got=%h busy=%b rdy=%b want=0 busy=0 rdy=1",
               ctrl, busy, cmd_ready);
    end
    #4;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || ctrl !== '0) begin
      failures++; $display("FAIL arst_release rdy=%b ctrl=%h want rdy=1 ctrl=0", cmd_ready, ctrl);
    end
    drive(MODE_STATIC, 6'b000001, 32'h8000_0000, 8'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    exp_a = '0;
    exp_a[SIG_CLK_SH*COLS +: COLS] = 32'h8000_0000;
    checks++;
    if (ctrl !== exp_a || busy !== 1'b0) begin
      failures++; $display("FAIL arst_static got=%h busy=%b want=%h busy=0", ctrl, busy, exp_a);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_static();
    test_pulse();
    test_len0();
    test_soft_clr_idle();
    test_overlap();
    test_soft_clr_pulse();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
